// File: rtl/hex_display_pkg.sv
// Shared constants and FSM state encoding for the labkit hex display driver.
package hex_display_pkg;

   localparam int NUM_DIGITS    = 16;
   localparam int COLS_PER_CHAR = 5;
   localparam int ROWS          = 8;
   localparam int FRAME_BITS    = NUM_DIGITS * COLS_PER_CHAR * ROWS;
   localparam int CTRL_BITS     = 8;
   localparam int GLYPH_BITS    = COLS_PER_CHAR * ROWS;

   typedef enum logic [2:0] {
      RESET_PULSE,
      RESET_WAIT,
      CTRL_LOAD,
      CTRL_LATCH,
      DOT_LOAD,
      DOT_LATCH
   } disp_state_e;

endpackage

// File: rtl/hex_font_rom.sv
// 5x7 hex font: glyph[39:32] is column 0, each column byte sent bit 7 first.
module hex_font_rom
   import hex_display_pkg::*;
(
   input  logic [3:0]            nibble,
   output logic [GLYPH_BITS-1:0] glyph
);

   // Bit 7 of every column is left clear so the top row stays dark.
   always_comb begin
      glyph = '0;
      case (nibble)
         4'h0: glyph = 40'h3E_51_49_45_3E;
         4'h1: glyph = 40'h00_42_7F_40_00;
         4'h2: glyph = 40'h42_61_51_49_46;
         4'h3: glyph = 40'h21_41_45_4B_31;
         4'h4: glyph = 40'h18_14_12_7F_10;
         4'h5: glyph = 40'h27_45_45_45_39;
         4'h6: glyph = 40'h3C_4A_49_49_30;
         4'h7: glyph = 40'h01_71_09_05_03;
         4'h8: glyph = 40'h36_49_49_49_36;
         4'h9: glyph = 40'h06_49_49_29_1E;
         4'hA: glyph = 40'h7E_11_11_11_7E;
         4'hB: glyph = 40'h7F_49_49_49_36;
         4'hC: glyph = 40'h3E_41_41_41_22;
         4'hD: glyph = 40'h7F_41_41_22_1C;
         4'hE: glyph = 40'h7F_49_49_49_41;
         4'hF: glyph = 40'h7F_09_09_09_01;
      endcase
   end

endmodule

// File: rtl/hex_display_driver.sv
// Serial driver for the labkit 16-character dot-matrix display; refreshes
// continuously from snapshots of a 64-bit hex word.
//
// state       | meaning
// ------------+---------------------------------------------------------
// RESET_PULSE | disp_reset_b held low for RESET_TICKS disp_clock periods
// RESET_WAIT  | one idle period after display reset release
// CTRL_LOAD   | shifting CTRL_WORD into the control register (rs = 1)
// CTRL_LATCH  | control word latched, blanking released
// DOT_LOAD    | shifting the 640-bit dot frame snapshotted on entry
// DOT_LATCH   | dot frame latched, frame_done pulsed
module hex_display_driver
   import hex_display_pkg::*;
#(
   parameter int unsigned          CLK_DIV     = 27,
   parameter int unsigned          RESET_TICKS = 4,
   parameter logic [CTRL_BITS-1:0] CTRL_WORD   = 8'h7F
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [63:0] data,
   output logic        disp_clock,
   output logic        disp_data_out,
   output logic        disp_rs,
   output logic        disp_ce_b,
   output logic        disp_reset_b,
   output logic        disp_blank,
   output logic        frame_done
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int RST_W = $clog2(RESET_TICKS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [RST_W-1:0] RST_LAST   = RST_W'(RESET_TICKS - 1);
   localparam logic [9:0]       FRAME_LAST = 10'(FRAME_BITS - 1);
   localparam logic [9:0]       CTRL_LAST  = 10'(CTRL_BITS - 1);
   localparam logic [5:0]       GLYPH_LAST = 6'(GLYPH_BITS - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             disp_clock_q, disp_clock_d;
   disp_state_e      state_q, state_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [9:0]       bit_cnt_q, bit_cnt_d;
   logic [3:0]       digit_q, digit_d;
   logic [5:0]       char_pos_q, char_pos_d;
   logic [63:0]      frame_reg_q, frame_reg_d;
   logic             data_out_q, data_out_d;
   logic             rs_q, rs_d;
   logic             ce_b_q, ce_b_d;
   logic             reset_b_q, reset_b_d;
   logic             blank_q, blank_d;
   logic             frame_done_q, frame_done_d;

   logic                  fall_tick;
   logic                  pos_last;
   logic [5:0]            char_pos_nxt;
   logic [3:0]            digit_nxt;
   logic [3:0]            rom_nibble;
   logic [GLYPH_BITS-1:0] rom_glyph;

   assign fall_tick    = (div_cnt_q == DIV_LAST) && disp_clock_q;
   assign pos_last     = (char_pos_q == GLYPH_LAST);
   assign char_pos_nxt = pos_last ? 6'd0 : char_pos_q + 1'b1;
   assign digit_nxt    = pos_last ? digit_q - 1'b1 : digit_q;
   // Look ahead to the bit being presented on this tick, not the current one.
   assign rom_nibble   = frame_reg_q[{digit_nxt, 2'b00} +: 4];

   hex_font_rom u_font_rom (
      .nibble (rom_nibble),
      .glyph  (rom_glyph)
   );

   always_comb begin
      div_cnt_d    = div_cnt_q + 1'b1;
      disp_clock_d = disp_clock_q;
      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d    = '0;
         disp_clock_d = ~disp_clock_q;
      end

      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      digit_d      = digit_q;
      char_pos_d   = char_pos_q;
      frame_reg_d  = frame_reg_q;
      data_out_d   = data_out_q;
      rs_d         = rs_q;
      ce_b_d       = ce_b_q;
      reset_b_d    = reset_b_q;
      blank_d      = blank_q;
      frame_done_d = 1'b0;

      if (fall_tick) begin
         unique case (state_q)
            RESET_PULSE: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_d   = RESET_WAIT;
                  reset_b_d = 1'b1;
                  rst_cnt_d = '0;
               end else begin
                  rst_cnt_d = rst_cnt_q + 1'b1;
               end
            end
            RESET_WAIT: begin
               state_d    = CTRL_LOAD;
               rs_d       = 1'b1;
               ce_b_d     = 1'b0;
               bit_cnt_d  = '0;
               data_out_d = CTRL_WORD[CTRL_BITS-1];
            end
            CTRL_LOAD: begin
               if (bit_cnt_q == CTRL_LAST) begin
                  state_d    = CTRL_LATCH;
                  ce_b_d     = 1'b1;
                  rs_d       = 1'b0;
                  blank_d    = 1'b0;
                  data_out_d = 1'b0;
                  bit_cnt_d  = '0;
               end else begin
                  bit_cnt_d  = bit_cnt_q + 1'b1;
                  data_out_d = CTRL_WORD[3'(CTRL_BITS - 2) - bit_cnt_q[2:0]];
               end
            end
            CTRL_LATCH, DOT_LATCH: begin
               // First bit of a frame is a blank top-row bit, so the ROM
               // is not needed while frame_reg is still loading.
               state_d     = DOT_LOAD;
               frame_reg_d = data;
               ce_b_d      = 1'b0;
               rs_d        = 1'b0;
               bit_cnt_d   = '0;
               digit_d     = 4'hF;
               char_pos_d  = '0;
               data_out_d  = 1'b0;
            end
            DOT_LOAD: begin
               if (bit_cnt_q == FRAME_LAST) begin
                  state_d      = DOT_LATCH;
                  ce_b_d       = 1'b1;
                  frame_done_d = 1'b1;
                  bit_cnt_d    = '0;
                  data_out_d   = 1'b0;
               end else begin
                  bit_cnt_d  = bit_cnt_q + 1'b1;
                  char_pos_d = char_pos_nxt;
                  digit_d    = digit_nxt;
                  data_out_d = rom_glyph[GLYPH_LAST - char_pos_nxt];
               end
            end
            default: begin
               state_d = RESET_PULSE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q    <= '0;
         disp_clock_q <= 1'b0;
         state_q      <= RESET_PULSE;
         rst_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         digit_q      <= '0;
         char_pos_q   <= '0;
         frame_reg_q  <= '0;
         data_out_q   <= 1'b0;
         rs_q         <= 1'b0;
         ce_b_q       <= 1'b1;
         reset_b_q    <= 1'b0;
         blank_q      <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         disp_clock_q <= disp_clock_d;
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         digit_q      <= digit_d;
         char_pos_q   <= char_pos_d;
         frame_reg_q  <= frame_reg_d;
         data_out_q   <= data_out_d;
         rs_q         <= rs_d;
         ce_b_q       <= ce_b_d;
         reset_b_q    <= reset_b_d;
         blank_q      <= blank_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign disp_clock    = disp_clock_q;
   assign disp_data_out = data_out_q;
   assign disp_rs       = rs_q;
   assign disp_ce_b     = ce_b_q;
   assign disp_reset_b  = reset_b_q;
   assign disp_blank    = blank_q;
   assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Scoreboarded bench for hex_display_driver: captures every shifted word on
// disp_clock rising edges and compares it against the expected snapshot.
module tb_hex_display_driver;

   localparam int CLK_DIV     = 2;
   localparam int RESET_TICKS = 4;
   localparam int FRAME_N     = 640;
   localparam int WAIT_LIMIT  = 5000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] data;
   logic        disp_clock;
   logic        disp_data_out;
   logic        disp_rs;
   logic        disp_ce_b;
   logic        disp_reset_b;
   logic        disp_blank;
   logic        frame_done;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [63:0] sb_q[$];
   logic        bits [0:FRAME_N-1];
   int unsigned nbits = 0;
   int unsigned dot_frames = 0;
   int unsigned ctrl_words = 0;
   int unsigned fd_cycles = 0;
   int unsigned timing_viol = 0;
   int unsigned period_viol = 0;
   int unsigned cyc_since_rise = 0;
   logic        word_rs = 1'b0;
   logic        word_blank = 1'b0;
   logic        have_rise = 1'b0;
   logic        clk_prev = 1'b0;
   logic        ce_prev = 1'b1;
   logic        do_prev = 1'b0;
   logic        rs_prev = 1'b0;

   hex_display_driver #(
      .CLK_DIV     (CLK_DIV),
      .RESET_TICKS (RESET_TICKS),
      .CTRL_WORD   (8'h7F)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .data          (data),
      .disp_clock    (disp_clock),
      .disp_data_out (disp_data_out),
      .disp_rs       (disp_rs),
      .disp_ce_b     (disp_ce_b),
      .disp_reset_b  (disp_reset_b),
      .disp_blank    (disp_blank),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [39:0] font(input logic [3:0] n);
      case (n)
         4'h0: font = 40'h3E_51_49_45_3E;
         4'h1: font = 40'h00_42_7F_40_00;
         4'h2: font = 40'h42_61_51_49_46;
         4'h3: font = 40'h21_41_45_4B_31;
         4'h4: font = 40'h18_14_12_7F_10;
         4'h5: font = 40'h27_45_45_45_39;
         4'h6: font = 40'h3C_4A_49_49_30;
         4'h7: font = 40'h01_71_09_05_03;
         4'h8: font = 40'h36_49_49_49_36;
         4'h9: font = 40'h06_49_49_29_1E;
         4'hA: font = 40'h7E_11_11_11_7E;
         4'hB: font = 40'h7F_49_49_49_36;
         4'hC: font = 40'h3E_41_41_41_22;
         4'hD: font = 40'h7F_41_41_22_1C;
         4'hE: font = 40'h7F_49_49_49_41;
         default: font = 40'h7F_09_09_09_01;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic word_done();
      logic [7:0]  w;
      logic [39:0] g;
      logic [63:0] exp;
      int          zero_viol;
      if (word_rs) begin
         ctrl_words++;
         for (int j = 0; j < 8; j++) w[7-j] = bits[j];
         check_eq("ctrl_len", 64'(nbits), 64'd8);
         check_eq("ctrl_word", {56'd0, w}, 64'h7F);
         check_eq("ctrl_blank_before_latch", {63'd0, word_blank}, 64'd1);
         check_eq("ctrl_blank_after_latch", {63'd0, disp_blank}, 64'd0);
         check_eq("ctrl_no_frame_done", {63'd0, frame_done}, 64'd0);
      end else begin
         dot_frames++;
         check_eq("dot_len", 64'(nbits), 64'(FRAME_N));
         check_eq("dot_frame_done", {63'd0, frame_done}, 64'd1);
         check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            for (int k = 0; k < 16; k++) begin
               for (int j = 0; j < 40; j++) g[39-j] = bits[40*k + j];
               check_eq($sformatf("dot_frame%0d_digit%0d", dot_frames, 15 - k),
                        {24'd0, g}, {24'd0, font(exp[63 - 4*k -: 4])});
            end
         end
         zero_viol = 0;
         for (int j = 0; j < FRAME_N; j += 8) if (bits[j] !== 1'b0) zero_viol++;
         check_eq("dot_row7_blank", 64'(zero_viol), 64'd0);
      end
      nbits = 0;
   endtask

   // Capture monitor: samples on clk falling edges, away from DUT updates.
   always @(negedge clk) begin
      if (reset_n !== 1'b1) begin
         clk_prev = 1'b0; ce_prev = 1'b1; do_prev = 1'b0; rs_prev = 1'b0;
         nbits = 0; have_rise = 1'b0; cyc_since_rise = 0;
      end else begin
         cyc_since_rise++;
         if ((disp_data_out !== do_prev || disp_ce_b !== ce_prev || disp_rs !== rs_prev)
             && !(clk_prev && !disp_clock))
            timing_viol++;
         if (disp_clock && !clk_prev) begin
            if (have_rise && cyc_since_rise != 2*CLK_DIV) period_viol++;
            have_rise = 1'b1;
            cyc_since_rise = 0;
            if (!disp_ce_b) begin
               if (nbits < FRAME_N) bits[nbits] = disp_data_out;
               word_rs = disp_rs;
               word_blank = disp_blank;
               nbits++;
            end
         end
         if (frame_done) fd_cycles++;
         if (disp_ce_b && !ce_prev) word_done();
         clk_prev = disp_clock; ce_prev = disp_ce_b;
         do_prev = disp_data_out; rs_prev = disp_rs;
      end
   end

   task automatic wait_frame_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (!frame_done && n < WAIT_LIMIT);
      check_eq(tag, {63'd0, frame_done}, 64'd1);
   endtask

   task automatic wait_bits(input string tag, input int unsigned target);
      int n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (!(nbits >= target && !disp_ce_b && !disp_rs) && n < WAIT_LIMIT);
      check_eq(tag, 64'(nbits >= target), 64'd1);
   endtask

   task automatic release_and_measure(input string tag);
      int n = 0;
      int ce_low = 0;
      @(negedge clk); #1;
      reset_n = 1'b1;
      do begin
         @(posedge clk); #1; n++;
         if (!disp_ce_b) ce_low++;
      end while (!disp_reset_b && n < 200);
      check_eq({tag, "_reset_b_width"}, 64'(n), 64'(RESET_TICKS * 2 * CLK_DIV));
      check_eq({tag, "_ce_b_high_in_reset"}, 64'(ce_low), 64'd0);
      check_eq({tag, "_blank_in_reset"}, {63'd0, disp_blank}, 64'd1);
   endtask

   initial begin
      int   toggles;
      logic prev;
      reset_n = 1'b0;
      data    = 64'h0123_4567_89AB_CDEF;
      sb_q.push_back(data);

      repeat (2) @(negedge clk);
      toggles = 0;
      prev = disp_clock;
      repeat (6) begin
         @(negedge clk);
         if (disp_clock !== prev) toggles++;
         prev = disp_clock;
      end
      check_eq("rst_clock_idle", 64'(toggles), 64'd0);
      check_eq("rst_disp_clock", {63'd0, disp_clock}, 64'd0);
      check_eq("rst_data_out", {63'd0, disp_data_out}, 64'd0);
      check_eq("rst_rs", {63'd0, disp_rs}, 64'd0);
      check_eq("rst_ce_b", {63'd0, disp_ce_b}, 64'd1);
      check_eq("rst_reset_b", {63'd0, disp_reset_b}, 64'd0);
      check_eq("rst_blank", {63'd0, disp_blank}, 64'd1);
      check_eq("rst_frame_done", {63'd0, frame_done}, 64'd0);

      release_and_measure("init1");
      wait_frame_done("frame1_done");

      data = 64'h0;
      sb_q.push_back(data);
      wait_bits("frame2_bit300", 300);
      data = '1;
      sb_q.push_back(data);
      wait_frame_done("frame2_done");
      wait_frame_done("frame3_done");

      wait_bits("frame4_bit100", 100);
      reset_n = 1'b0;
      #1;
      check_eq("midrst_ce_b", {63'd0, disp_ce_b}, 64'd1);
      check_eq("midrst_reset_b", {63'd0, disp_reset_b}, 64'd0);
      check_eq("midrst_blank", {63'd0, disp_blank}, 64'd1);
      check_eq("midrst_rs", {63'd0, disp_rs}, 64'd0);
      check_eq("frames_before_reset", 64'(dot_frames), 64'd3);
      repeat (5) @(negedge clk);
      check_eq("midrst_clock_idle", {63'd0, disp_clock}, 64'd0);

      data = 64'hFEDC_BA98_7654_3210;
      sb_q.push_back(data);
      release_and_measure("init2");
      wait_frame_done("frame5_done");
      repeat (8) @(negedge clk);

      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
      check_eq("dot_frame_count", 64'(dot_frames), 64'd4);
      check_eq("ctrl_word_count", 64'(ctrl_words), 64'd2);
      check_eq("frame_done_cycles", 64'(fd_cycles), 64'd4);
      check_eq("timing_violations", 64'(timing_viol), 64'd0);
      check_eq("period_violations", 64'(period_viol), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
